// File: rtl/ccx_mem_arbiter.sv
// ccx_mem_arbiter: two-requestor arbiter between the instruction fetch (imem)
// and data access (dmem) requestors and the core memory bus responder (mem).
// The owner is locked until its gnt, and the response is routed to the owner only.
// Optional feature macro: CCX_ARB_RR_EN selects round-robin arbitration.
// When the macro is undefined, arbitration is fixed priority (dmem wins), with
// an imem anti-starvation override after STARVE_MAX consecutive losses.
module ccx_mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        imem_req,
    input  logic        imem_rtype,
    input  logic        imem_prv,
    input  logic [38:0] imem_addr,
    input  logic        imem_wen,
    input  logic [7:0]  imem_strb,
    input  logic [63:0] imem_wdata,
    output logic        imem_gnt,
    output logic        imem_err,
    output logic [63:0] imem_rdata,

    input  logic        dmem_req,
    input  logic        dmem_rtype,
    input  logic        dmem_prv,
    input  logic [38:0] dmem_addr,
    input  logic        dmem_wen,
    input  logic [7:0]  dmem_strb,
    input  logic [63:0] dmem_wdata,
    output logic        dmem_gnt,
    output logic        dmem_err,
    output logic [63:0] dmem_rdata,

    output logic        mem_req,
    output logic        mem_rtype,
    output logic        mem_prv,
    output logic [38:0] mem_addr,
    output logic        mem_wen,
    output logic [7:0]  mem_strb,
    output logic [63:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_err,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   sel_i, sel_d;
    logic   contested;
    logic   prefer_i;

    // Requestor rtype is overridden by the arbiter; the inputs are kept for bus compatibility.
    logic   unused_rtype;
    assign unused_rtype = imem_rtype ^ dmem_rtype;

    assign contested = imem_req & dmem_req;

`ifdef CCX_ARB_RR_EN
    // rr_ptr: 1 = dmem preferred, 0 = imem preferred.
    logic rr_ptr, rr_ptr_nxt;
    logic rr_contested, rr_contested_nxt;

    assign prefer_i = ~rr_ptr;
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_cnt, starve_cnt_nxt;

    assign prefer_i = (starve_cnt == STARVE_LIM);
`endif

    // State register for ownership.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration and ownership next-state; selection is forced off during reset.
    always_comb begin
        sel_i     = 1'b0;
        sel_d     = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                sel_i = imem_req & (~dmem_req | prefer_i);
                sel_d = dmem_req & ~sel_i;
                if ((sel_i | sel_d) && !mem_gnt) begin
                    state_nxt = sel_i ? OWN_I : OWN_D;
                end
            end
            OWN_I: begin
                sel_i = imem_req;
                if (mem_gnt || !imem_req) begin
                    state_nxt = IDLE;
                end
            end
            OWN_D: begin
                sel_d = dmem_req;
                if (mem_gnt || !dmem_req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!g_resetn) begin
            sel_i = 1'b0;
            sel_d = 1'b0;
        end
    end

`ifdef CCX_ARB_RR_EN
    // Round-robin pointer and contested-ownership flag registers.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rr_ptr       <= 1'b1;
            rr_contested <= 1'b0;
        end else begin
            rr_ptr       <= rr_ptr_nxt;
            rr_contested <= rr_contested_nxt;
        end
    end

    // Flip preference to the loser once a contested transaction completes.
    always_comb begin
        rr_ptr_nxt       = rr_ptr;
        rr_contested_nxt = rr_contested;
        if (state == IDLE) begin
            rr_contested_nxt = contested;
            if (contested && mem_gnt) begin
                rr_ptr_nxt = sel_i;
            end
        end else if ((sel_i | sel_d) && mem_gnt && rr_contested) begin
            rr_ptr_nxt = sel_i;
        end
    end
`else
    // Starvation counter register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Count contested dmem wins (saturating); any imem win clears the count.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (state == IDLE) begin
            if (sel_i) begin
                starve_cnt_nxt = '0;
            end else if (sel_d && contested && (starve_cnt != STARVE_LIM)) begin
                starve_cnt_nxt = starve_cnt + 4'd1;
            end
        end
    end
`endif

    // Request mux toward mem and response routing back to the owner only.
    always_comb begin
        mem_req    = sel_i | sel_d;
        mem_rtype  = sel_d;
        mem_prv    = 1'b0;
        mem_addr   = '0;
        mem_wen    = 1'b0;
        mem_strb   = '0;
        mem_wdata  = '0;
        imem_gnt   = 1'b0;
        imem_err   = 1'b0;
        imem_rdata = '0;
        dmem_gnt   = 1'b0;
        dmem_err   = 1'b0;
        dmem_rdata = '0;
        if (sel_i) begin
            mem_prv    = imem_prv;
            mem_addr   = imem_addr;
            mem_wen    = imem_wen;
            mem_strb   = imem_strb;
            mem_wdata  = imem_wdata;
            imem_gnt   = mem_gnt;
            imem_err   = mem_err;
            imem_rdata = mem_rdata;
        end else if (sel_d) begin
            mem_prv    = dmem_prv;
            mem_addr   = dmem_addr;
            mem_wen    = dmem_wen;
            mem_strb   = dmem_strb;
            mem_wdata  = dmem_wdata;
            dmem_gnt   = mem_gnt;
            dmem_err   = mem_err;
            dmem_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_ccx_mem_arbiter.sv
// Self-checking bench for ccx_mem_arbiter: directed scenarios followed by
// randomized protocol traffic, compared against a transaction-level model.
module tb_ccx_mem_arbiter;

    localparam int unsigned S = 4;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        imem_req, imem_rtype, imem_prv, imem_wen;
    logic [38:0] imem_addr;
    logic [7:0]  imem_strb;
    logic [63:0] imem_wdata;
    logic        imem_gnt, imem_err;
    logic [63:0] imem_rdata;
    logic        dmem_req, dmem_rtype, dmem_prv, dmem_wen;
    logic [38:0] dmem_addr;
    logic [7:0]  dmem_strb;
    logic [63:0] dmem_wdata;
    logic        dmem_gnt, dmem_err;
    logic [63:0] dmem_rdata;
    logic        mem_req, mem_rtype, mem_prv, mem_wen;
    logic [38:0] mem_addr;
    logic [7:0]  mem_strb;
    logic [63:0] mem_wdata;
    logic        mem_gnt, mem_err;
    logic [63:0] mem_rdata;

    ccx_mem_arbiter #(.STARVE_MAX(S)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .imem_req(imem_req), .imem_rtype(imem_rtype), .imem_prv(imem_prv),
        .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_strb(imem_strb),
        .imem_wdata(imem_wdata), .imem_gnt(imem_gnt), .imem_err(imem_err),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_rtype(dmem_rtype), .dmem_prv(dmem_prv),
        .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_err(dmem_err),
        .dmem_rdata(dmem_rdata),
        .mem_req(mem_req), .mem_rtype(mem_rtype), .mem_prv(mem_prv),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_strb(mem_strb),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_err(mem_err),
        .mem_rdata(mem_rdata)
    );

    always #5 g_clk = ~g_clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: owner (0 none, 1 imem, 2 dmem), consecutive imem losses,
    // preferred requestor for round-robin, and whether ownership was contested.
    int m_owner, m_lost, m_pref;
    bit m_cont;
    int last_sel;
    bit last_gnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_lost   = 0;
        m_pref   = 2;
        m_cont   = 0;
        last_sel = 0;
        last_gnt = 0;
    endtask

    task automatic new_i();
        imem_prv   = 1'($urandom);
        imem_wen   = 1'($urandom);
        imem_strb  = 8'($urandom);
        imem_addr  = 39'({$urandom, $urandom});
        imem_wdata = {$urandom, $urandom};
        imem_rtype = 1'($urandom);
    endtask

    task automatic new_d();
        dmem_prv   = 1'($urandom);
        dmem_wen   = 1'($urandom);
        dmem_strb  = 8'($urandom);
        dmem_addr  = 39'({$urandom, $urandom});
        dmem_wdata = {$urandom, $urandom};
        dmem_rtype = 1'($urandom);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_mem"}, {mem_req, mem_rtype, mem_prv, mem_wen, mem_strb, mem_wdata, mem_addr}, '0);
        chk({tag, "_irsp"}, {imem_gnt, imem_err, imem_rdata}, '0);
        chk({tag, "_drsp"}, {dmem_gnt, dmem_err, dmem_rdata}, '0);
    endtask

    // Assert reset now (possibly mid-cycle), check outputs, release on a later negedge.
    task automatic do_reset();
        mem_gnt   = 1'b1;
        mem_err   = 1'b1;
        mem_rdata = {$urandom, $urandom};
        g_resetn  = 1'b0;
        #1;
        rst_chk("reset_async");
        @(negedge g_clk);
        @(negedge g_clk);
        rst_chk("reset_hold");
        g_resetn = 1'b1;
        mem_gnt  = 1'b0;
        mem_err  = 1'b0;
        model_reset();
    endtask

    // One clock: inputs are already applied at the negedge; check, advance model.
    task automatic cycle();
        int sel;
        bit cont;
        logic [112:0] ep;
        logic [65:0]  ei, ed;
        #1;
        cont = imem_req && dmem_req;
        if (m_owner == 1)      sel = imem_req ? 1 : 0;
        else if (m_owner == 2) sel = dmem_req ? 2 : 0;
        else if (cont) begin
`ifdef CCX_ARB_RR_EN
            sel = m_pref;
`else
            sel = (m_lost == S) ? 1 : 2;
`endif
        end
        else sel = imem_req ? 1 : (dmem_req ? 2 : 0);

        ep = '0; ei = '0; ed = '0;
        if (sel == 1) begin
            ep = {imem_prv, imem_wen, imem_strb, imem_wdata, imem_addr};
            ei = {mem_gnt, mem_err, mem_rdata};
        end else if (sel == 2) begin
            ep = {dmem_prv, dmem_wen, dmem_strb, dmem_wdata, dmem_addr};
            ed = {mem_gnt, mem_err, mem_rdata};
        end
        chk("mem_req", mem_req, sel != 0);
        chk("mem_rtype", mem_rtype, sel == 2);
        chk("mem_payload", {mem_prv, mem_wen, mem_strb, mem_wdata, mem_addr}, ep);
        chk("imem_rsp", {imem_gnt, imem_err, imem_rdata}, ei);
        chk("dmem_rsp", {dmem_gnt, dmem_err, dmem_rdata}, ed);

        if (m_owner == 0) begin
            if (sel == 1) m_lost = 0;
            else if (sel == 2 && cont && m_lost < S) m_lost++;
            m_cont = cont;
        end
        if (sel != 0 && mem_gnt && m_cont) m_pref = (sel == 1) ? 2 : 1;
        m_owner  = (sel != 0 && !mem_gnt) ? sel : 0;
        last_sel = sel;
        last_gnt = mem_gnt;
        @(negedge g_clk);
    endtask

    bit i_act, d_act;

    initial begin
        g_resetn  = 1'b1;
        imem_req  = 1'b1;
        dmem_req  = 1'b1;
        new_i();
        new_d();
        mem_gnt   = 1'b1;
        mem_err   = 1'b0;
        mem_rdata = '0;
        model_reset();

        // Reset with both requesting: everything quiet, then dmem selected first.
        #1;
        do_reset();
        #1;
        chk("t1_first_sel", {mem_req, mem_rtype}, 2'b11);
        cycle();
        mem_gnt = 1'b1;
        mem_rdata = {$urandom, $urandom};
        cycle();
        imem_req = 1'b0;
        dmem_req = 1'b0;
        mem_gnt  = 1'b0;
        cycle();

        // imem alone at 0x1000, responder grants after 3 cycles.
        new_i();
        imem_addr = 39'h1000;
        imem_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_gnt   = (k == 3);
            mem_rdata = {$urandom, $urandom};
            #1;
            chk("t2_addr", {mem_rtype, mem_addr}, {1'b0, 39'h1000});
            chk("t2_gnts", {imem_gnt, dmem_gnt}, {(k == 3), 1'b0});
            cycle();
        end
        imem_req = 1'b0;
        mem_gnt  = 1'b0;
        cycle();

        // imem owns; dmem requests meanwhile and waits until imem completes.
        new_i();
        imem_req = 1'b1;
        cycle();
        new_d();
        dmem_req = 1'b1;
        #1;
        chk("t3_lock", {mem_rtype, dmem_gnt}, 2'b00);
        cycle();
        mem_gnt = 1'b1;
        cycle();
        imem_req = 1'b0;
        mem_gnt  = 1'b0;
        #1;
        chk("t3_dmem_next", {mem_req, mem_rtype}, 2'b11);
        cycle();
        mem_gnt = 1'b1;
        cycle();
        dmem_req = 1'b0;
        mem_gnt  = 1'b0;

        // Owner drops req before gnt: mem_req low that cycle, then back to IDLE.
        new_d();
        dmem_req = 1'b1;
        cycle();
        dmem_req = 1'b0;
        cycle();
        new_i();
        imem_req = 1'b1;
        mem_gnt  = 1'b1;
        cycle();
        imem_req = 1'b0;
        mem_gnt  = 1'b0;
        cycle();

        // Sustained contention with a grant every cycle: check grant order.
        do_reset();
        imem_req = 1'b1;
        dmem_req = 1'b1;
        mem_gnt  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            mem_rdata = {$urandom, $urandom};
            #1;
`ifdef CCX_ARB_RR_EN
            chk("t4_order", {imem_gnt, dmem_gnt}, (k % 2 == 0) ? 2'b01 : 2'b10);
`else
            chk("t4_order", {imem_gnt, dmem_gnt}, (k % 5 == 4) ? 2'b10 : 2'b01);
`endif
            cycle();
        end
        imem_req = 1'b0;
        dmem_req = 1'b0;
        mem_gnt  = 1'b0;
        cycle();

        // Reset while dmem owns with gnt pending; then err routing to owner only.
        new_d();
        dmem_req = 1'b1;
        cycle();
        #3;
        do_reset();
        new_i();
        imem_req  = 1'b1;
        mem_gnt   = 1'b1;
        mem_err   = 1'b1;
        mem_rdata = {$urandom, $urandom};
        #1;
        chk("t6_err_d", {imem_err, dmem_err}, 2'b01);
        cycle();
        dmem_req = 1'b0;
        #1;
        chk("t6_err_i", {imem_err, dmem_err}, 2'b10);
        cycle();
        imem_req = 1'b0;
        mem_gnt  = 1'b0;
        mem_err  = 1'b0;
        cycle();

        // Randomized protocol traffic with occasional early drops.
        i_act = 0;
        d_act = 0;
        for (int n = 0; n < 3000; n++) begin
            if (last_sel == 1 && last_gnt) i_act = 0;
            if (last_sel == 2 && last_gnt) d_act = 0;
            if (i_act && ($urandom % 40 == 0)) i_act = 0;
            else if (!i_act && ($urandom % 3 == 0)) begin i_act = 1; new_i(); end
            if (d_act && ($urandom % 40 == 0)) d_act = 0;
            else if (!d_act && ($urandom % 2 == 0)) begin d_act = 1; new_d(); end
            imem_req  = i_act;
            dmem_req  = d_act;
            mem_gnt   = ($urandom % 3 == 0);
            mem_err   = ($urandom % 4 == 0);
            mem_rdata = {$urandom, $urandom};
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
